// File: rtl/jtag_cmd_arbiter.sv
// Round-robin arbiter sharing one JTAG TAP command port among NUM_REQ requesters.
// The grant is locked for a whole burst and, optionally, until the TAP queue drains.
module jtag_cmd_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int CMD_LEN   = 4,
  parameter int CYCLE_LEN = 28,
  parameter bit WAIT_DONE = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ*CMD_LEN-1:0]     req_cmd,
  input  logic [NUM_REQ*CYCLE_LEN-1:0]   req_cycle_num,
  input  logic [NUM_REQ-1:0]             req_last,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [CMD_LEN-1:0]             cmd,
  output logic [CYCLE_LEN-1:0]           cycle_num,
  output logic                           cmd_valid,
  input  logic                           cmd_ready,
  input  logic                           cmd_done,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           busy,
  output logic [NUM_REQ-1:0]             xact_done
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_DRAIN
  } arb_state_t;

  arb_state_t       state;
  logic [IDX_W-1:0] last_owner;
  logic [IDX_W-1:0] winner;
  logic             found;
  logic [IDX_W:0]   rr_sum;
  logic             owner_valid;
  logic             owner_last;
  logic             owner_fire;

  // Search starts one past the previous owner so every requester gets a turn.
  always_comb begin : rr_search
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    found  = 1'b0;
    winner = '0;
    rr_sum = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_sum = {1'b0, last_owner} + (IDX_W+1)'(k);
      if (rr_sum >= (IDX_W+1)'(NUM_REQ)) begin
        rr_sum = rr_sum - (IDX_W+1)'(NUM_REQ);
      end
      if (!found && req_valid[rr_sum[IDX_W-1:0]]) begin
        found  = 1'b1;
        winner = rr_sum[IDX_W-1:0];
      end
    end
  end

  always_comb begin : fwd_mux
    cmd         = '0;
    cycle_num   = '0;
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    req_ready   = '0;
    if (state == ARB_GRANT) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) begin
          cmd          = req_cmd[i*CMD_LEN +: CMD_LEN];
          cycle_num    = req_cycle_num[i*CYCLE_LEN +: CYCLE_LEN];
          owner_valid  = req_valid[i];
          owner_last   = req_last[i];
          req_ready[i] = cmd_ready;
        end
      end
    end
  end

  assign cmd_valid  = owner_valid;
  assign owner_fire = owner_valid & cmd_ready;

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_IDLE;
      grant      <= '0;
      busy       <= 1'b0;
      xact_done  <= '0;
      last_owner <= IDX_W'(NUM_REQ - 1);
    end else begin
      xact_done <= '0;
      case (state)
        ARB_IDLE: begin
          if (found) begin
            grant      <= NUM_REQ'(1) << winner;
            last_owner <= winner;
            busy       <= 1'b1;
            state      <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (owner_fire && owner_last) begin
            if (WAIT_DONE) begin
              state <= ARB_DRAIN;
            end else begin
              xact_done <= grant;
              grant     <= '0;
              busy      <= 1'b0;
              state     <= ARB_IDLE;
            end
          end
        end
        ARB_DRAIN: begin
          // cmd_done is only looked at here, so the drain lasts at least one cycle.
          if (cmd_done) begin
            xact_done <= grant;
            grant     <= '0;
            busy      <= 1'b0;
            state     <= ARB_IDLE;
          end
        end
        default: begin
          grant <= '0;
          busy  <= 1'b0;
          state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_cmd_arbiter.sv
// Self-checking bench for jtag_cmd_arbiter: round-robin vector table, scoreboard of
// forwarded entries, and hand-written burst, lock, backpressure and reset sequences.
module tb_jtag_cmd_arbiter;

  localparam int N  = 4;
  localparam int CL = 4;
  localparam int YL = 28;

  typedef struct packed {
    logic [CL-1:0] cmd;
    logic [YL-1:0] cyc;
  } entry_t;

  typedef struct {
    logic [N-1:0] valid;
    logic [N-1:0] grant;
  } rr_vec_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*CL-1:0] req_cmd;
  logic [N*YL-1:0] req_cycle_num;
  logic [N-1:0]    req_last, req_valid;
  logic [N-1:0]    req_ready, grant, xact_done;
  logic [CL-1:0]   cmd;
  logic [YL-1:0]   cycle_num;
  logic            cmd_valid, cmd_ready, cmd_done, busy;

  logic [N-1:0]    req_ready0, grant0, xact_done0;
  logic [CL-1:0]   cmd0;
  logic [YL-1:0]   cycle_num0;
  logic            cmd_valid0, busy0;

  int      errors   = 0;
  int      checks   = 0;
  int      hs_count = 0;
  bit      sb_en    = 1'b0;
  entry_t  sb_q[$];
  entry_t  exp_e;
  rr_vec_t vecs[12];

  jtag_cmd_arbiter #(.NUM_REQ(N), .CMD_LEN(CL), .CYCLE_LEN(YL), .WAIT_DONE(1'b1)) dut (
    .clk(clk), .rst(rst), .req_cmd(req_cmd), .req_cycle_num(req_cycle_num),
    .req_last(req_last), .req_valid(req_valid), .req_ready(req_ready),
    .cmd(cmd), .cycle_num(cycle_num), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_done(cmd_done), .grant(grant), .busy(busy), .xact_done(xact_done)
  );

  jtag_cmd_arbiter #(.NUM_REQ(N), .CMD_LEN(CL), .CYCLE_LEN(YL), .WAIT_DONE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .req_cmd(req_cmd), .req_cycle_num(req_cycle_num),
    .req_last(req_last), .req_valid(req_valid), .req_ready(req_ready0),
    .cmd(cmd0), .cycle_num(cycle_num0), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready),
    .cmd_done(cmd_done), .grant(grant0), .busy(busy0), .xact_done(xact_done0)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_entry(input int r, input logic [CL-1:0] c, input logic [YL-1:0] y,
                           input logic last, input logic v);
    req_cmd[r*CL +: CL]       = c;
    req_cycle_num[r*YL +: YL] = y;
    req_last[r]               = last;
    req_valid[r]              = v;
  endtask

  task automatic push(input logic [CL-1:0] c, input logic [YL-1:0] y);
    entry_t e;
    e.cmd = c;
    e.cyc = y;
    sb_q.push_back(e);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_cmd_valid"}, cmd_valid, 0);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_xact_done"}, xact_done, 0);
    check({tag, "_cmd"}, cmd, 0);
    check({tag, "_cycle_num"}, cycle_num, 0);
  endtask

  // Scoreboard: every handshake on the TAP side must match the next expected entry.
  always @(negedge clk) begin
    if (sb_en && cmd_valid && cmd_ready) begin
      hs_count++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra: unexpected handshake cmd=0x%0h cycle_num=%0d at %0t",
                 cmd, cycle_num, $time);
      end else begin
        exp_e = sb_q.pop_front();
        check("sb_cmd", cmd, exp_e.cmd);
        check("sb_cycle_num", cycle_num, exp_e.cyc);
      end
    end
  end

  initial begin
    int hs0;
    int e;

    vecs[0]  = '{4'b1111, 4'b0001};
    vecs[1]  = '{4'b1111, 4'b0010};
    vecs[2]  = '{4'b1111, 4'b0100};
    vecs[3]  = '{4'b1111, 4'b1000};
    vecs[4]  = '{4'b1111, 4'b0001};
    vecs[5]  = '{4'b1001, 4'b1000};
    vecs[6]  = '{4'b0011, 4'b0001};
    vecs[7]  = '{4'b0100, 4'b0100};
    vecs[8]  = '{4'b0011, 4'b0001};
    vecs[9]  = '{4'b1010, 4'b0010};
    vecs[10] = '{4'b0001, 4'b0001};
    vecs[11] = '{4'b1100, 4'b0100};

    rst = 1'b1;
    req_cmd = '0;
    req_cycle_num = '0;
    req_last = '0;
    req_valid = '0;
    cmd_ready = 1'b1;
    cmd_done = 1'b0;
    tick();
    tick();
    check_zero_outputs("reset");
    rst = 1'b0;
    sb_en = 1'b1;

    // Round-robin table: one single-entry transaction per vector.
    for (int v = 0; v < 12; v++) begin
      int w;
      w = 0;
      for (int i = 0; i < N; i++) if (vecs[v].grant[i]) w = i;
      for (int i = 0; i < N; i++) set_entry(i, CL'(i + v), YL'(v * 16 + i), 1'b1, vecs[v].valid[i]);
      push(CL'(w + v), YL'(v * 16 + w));
      #1;
      check("rr_idle_grant", grant, 0);
      tick();
      check("rr_grant", grant, vecs[v].grant);
      check("rr_req_ready", req_ready, vecs[v].grant);
      tick();
      req_valid = '0;
      #1;
      check("rr_drain_cmd_valid", cmd_valid, 0);
      check("rr_drain_busy", busy, 1);
      cmd_done = 1'b1;
      tick();
      cmd_done = 1'b0;
      #1;
      check("rr_xact_done", xact_done, vecs[v].grant);
      check("rr_release_busy", busy, 0);
    end

    // Single requester, three-entry burst.
    push(4'h3, 28'd10);
    push(4'h4, 28'd32);
    push(4'h4, 28'd8);
    hs0 = hs_count;
    set_entry(1, 4'h3, 28'd10, 1'b0, 1'b1);
    #1;
    check("single_idle_grant", grant, 0);
    tick();
    check("single_grant", grant, 4'b0010);
    check("single_busy", busy, 1);
    check("single_cmd0", cmd, 4'h3);
    tick();
    set_entry(1, 4'h4, 28'd32, 1'b0, 1'b1);
    #1;
    check("single_cycle1", cycle_num, 28'd32);
    tick();
    set_entry(1, 4'h4, 28'd8, 1'b1, 1'b1);
    #1;
    check("single_cycle2", cycle_num, 28'd8);
    tick();
    req_valid = '0;
    req_last = '0;
    #1;
    check("single_handshakes", hs_count - hs0, 3);
    check("single_drain_valid", cmd_valid, 0);
    check("single_drain_ready", req_ready, 0);
    check("single_drain_cmd", cmd, 0);
    check("single_drain_grant", grant, 4'b0010);
    for (int c = 0; c < 2; c++) begin
      tick();
      check("single_drain_hold", grant, 4'b0010);
      check("single_drain_nodone", xact_done, 0);
    end
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    #1;
    check("single_xact_done", xact_done, 4'b0010);
    check("single_release_grant", grant, 0);
    tick();
    check("single_xact_pulse", xact_done, 0);

    // Lock: req2 stalls mid-burst while req0 waits.
    push(4'h5, 28'd50);
    set_entry(2, 4'h5, 28'd50, 1'b0, 1'b1);
    tick();
    check("lock_grant", grant, 4'b0100);
    tick();
    req_valid[2] = 1'b0;
    set_entry(0, 4'h9, 28'd90, 1'b1, 1'b1);
    for (int c = 0; c < 20; c++) begin
      #1;
      check("lock_hold_grant", grant, 4'b0100);
      check("lock_req0_ready", req_ready[0], 0);
      check("lock_no_valid", cmd_valid, 0);
      tick();
    end
    push(4'h6, 28'd60);
    set_entry(2, 4'h6, 28'd60, 1'b0, 1'b1);
    tick();
    push(4'h7, 28'd70);
    set_entry(2, 4'h7, 28'd70, 1'b1, 1'b1);
    tick();
    req_valid[2] = 1'b0;
    push(4'h9, 28'd90);
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    #1;
    check("lock_xact_done", xact_done, 4'b0100);
    tick();
    check("lock_next_owner", grant, 4'b0001);
    tick();
    req_valid = '0;
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    #1;
    check("lock_req0_done", xact_done, 4'b0001);

    // Backpressure: cmd_ready toggles 1,0,1,0 while req3 sends four entries.
    for (int k = 0; k < 4; k++) push(CL'(10 + k), YL'(1000 + k));
    e = 0;
    set_entry(3, CL'(10), YL'(1000), 1'b0, 1'b1);
    tick();
    for (int c = 0; c < 20 && e < 4; c++) begin
      cmd_ready = (c % 2 == 0);
      set_entry(3, CL'(10 + e), YL'(1000 + e), e == 3, 1'b1);
      #1;
      check("bp_req_ready", req_ready[3], cmd_ready);
      if (cmd_ready) e++;
      tick();
    end
    check("bp_all_entries", e, 4);
    req_valid = '0;
    cmd_ready = 1'b1;
    cmd_done = 1'b1;
    #1;
    check("bp_drain_busy", busy, 1);
    check("bp_drain_valid", cmd_valid, 0);
    tick();
    cmd_done = 1'b0;
    #1;
    check("bp_xact_done", xact_done, 4'b1000);
    check("sb_drained", sb_q.size(), 0);

    // Reset mid-burst, then the first tie goes to requester 0.
    push(4'h2, 28'd20);
    set_entry(1, 4'h2, 28'd20, 1'b0, 1'b1);
    tick();
    tick();
    set_entry(1, 4'h3, 28'd30, 1'b0, 1'b1);
    cmd_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_pre_grant", grant, 4'b0010);
    tick();
    check_zero_outputs("rst_mid");
    rst = 1'b0;
    cmd_ready = 1'b1;
    for (int i = 0; i < N; i++) set_entry(i, CL'(8 + i), YL'(500 + i), 1'b1, 1'b1);
    push(4'h8, 28'd500);
    tick();
    check("rst_first_tie", grant, 4'b0001);
    tick();
    req_valid = '0;
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    #1;
    check("rst_xact_done", xact_done, 4'b0001);
    check("sb_empty", sb_q.size(), 0);

    // WAIT_DONE=0 instance: release on last-entry acceptance, cmd_done never raised.
    sb_en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("nw_reset_grant", grant0, 0);
    check("nw_reset_ready", req_ready0, 0);
    check("nw_reset_cmd", cmd0, 0);
    check("nw_reset_cycle", cycle_num0, 0);
    set_entry(1, 4'h1, 28'd11, 1'b0, 1'b1);
    tick();
    check("nw_grant", grant0, 4'b0010);
    check("nw_busy", busy0, 1);
    tick();
    set_entry(1, 4'h2, 28'd12, 1'b1, 1'b1);
    set_entry(2, 4'h5, 28'd15, 1'b1, 1'b1);
    #1;
    check("nw_last_valid", cmd_valid0, 1);
    tick();
    req_valid[1] = 1'b0;
    #1;
    check("nw_xact_done", xact_done0, 4'b0010);
    check("nw_release_grant", grant0, 0);
    check("nw_release_busy", busy0, 0);
    tick();
    check("nw_next_grant", grant0, 4'b0100);
    check("nw_xact_pulse", xact_done0, 0);
    req_valid = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
